// File: rtl/csr_mtrap_unit.sv
// Machine-mode CSR file and trap controller for a single-hart RV32 core:
// Zicsr accesses, trap/interrupt entry, mret, trap vector and mcycle/minstret.
module csr_mtrap_unit #(
   parameter int          NUM_LOCAL_IRQ = 4,
   parameter int          SYNC_STAGES   = 2,
   parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
   parameter bit          HAS_COUNTERS  = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [11:0]              csr_addr,
   input  logic [1:0]               csr_op,
   input  logic [31:0]              csr_wdata,
   output logic [31:0]              csr_rdata,
   output logic                     csr_illegal,
   input  logic                     trap_req,
   input  logic [4:0]               trap_cause,
   input  logic [31:0]              trap_tval,
   input  logic                     irq_sw,
   input  logic                     irq_timer,
   input  logic                     irq_ext,
   input  logic [NUM_LOCAL_IRQ-1:0] irq_local,
   output logic                     irq_valid,
   input  logic                     irq_take,
   input  logic                     mret,
   input  logic                     instr_retire,
   input  logic [31:0]              current_pc,
   output logic                     trap_taken,
   output logic [31:0]              trap_pc,
   output logic [31:0]              mepc_out
);

   localparam logic [31:0] LOCAL_MASK = (NUM_LOCAL_IRQ == 0) ? 32'h0 :
                                        (((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << 16);
   localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | LOCAL_MASK;

   logic                     r_mstatus_mie;
   logic                     r_mstatus_mpie;
   logic [31:0]              r_mie;
   logic [31:0]              r_mtvec;
   logic [31:0]              r_mscratch;
   logic [31:0]              r_mepc;
   logic [31:0]              r_mcause;
   logic [31:0]              r_mtval;
   logic                     r_msip;
   logic                     r_mtip;
   logic                     r_trap_taken;
   logic [63:0]              r_mcycle;
   logic [63:0]              r_minstret;
   logic [NUM_LOCAL_IRQ:0]   r_sync [SYNC_STAGES];

   logic [NUM_LOCAL_IRQ:0]   w_sync_out;
   logic [31:0]              w_mip;
   logic [31:0]              w_pending;
   logic [4:0]               w_irq_code;
   logic [31:0]              w_mstatus;
   logic [31:0]              w_old;
   logic [31:0]              w_wval;
   logic                     w_mapped;
   logic                     w_ro;
   logic                     w_do_write;
   logic                     w_csr_we;
   logic                     w_irq_entry;
   logic                     w_evt_block;
   logic                     w_csr_commit;
   logic [31:0]              w_base;

   // Bit 0 carries irq_ext, bits [N:1] carry the local interrupts
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= {irq_local, irq_ext};
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_sync_out = r_sync[SYNC_STAGES-1];

   always_comb begin
      w_mip     = '0;
      w_mip[3]  = r_msip;
      w_mip[7]  = r_mtip;
      w_mip[11] = w_sync_out[0];
      for (int i = 0; i < NUM_LOCAL_IRQ; i++) w_mip[16+i] = w_sync_out[i+1];
   end

   assign w_pending = w_mip & r_mie;
   assign irq_valid = r_mstatus_mie & (|w_pending);

   // Later assignments override earlier ones, giving 11 > 3 > 7 > lowest local
   always_comb begin
      w_irq_code = 5'd0;
      for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
         if (w_pending[16+i]) w_irq_code = 5'(16 + i);
      end
      if (w_pending[7])  w_irq_code = 5'd7;
      if (w_pending[3])  w_irq_code = 5'd3;
      if (w_pending[11]) w_irq_code = 5'd11;
   end

   assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

   always_comb begin
      w_old    = '0;
      w_mapped = 1'b1;
      w_ro     = 1'b0;
      case (csr_addr)
         12'h300: w_old = w_mstatus;
         12'h301: begin w_old = 32'h4000_0100; w_ro = 1'b1; end
         12'h304: w_old = r_mie;
         12'h305: w_old = r_mtvec;
         12'h340: w_old = r_mscratch;
         12'h341: w_old = r_mepc;
         12'h342: w_old = r_mcause;
         12'h343: w_old = r_mtval;
         12'h344: begin w_old = w_mip; w_ro = 1'b1; end
         12'hB00: w_old = r_mcycle[31:0];
         12'hB80: w_old = r_mcycle[63:32];
         12'hB02: w_old = r_minstret[31:0];
         12'hB82: w_old = r_minstret[63:32];
         12'hF14: begin w_old = 32'h0; w_ro = 1'b1; end
         default: w_mapped = 1'b0;
      endcase
   end

   always_comb begin
      case (csr_op)
         2'b01:   w_wval = csr_wdata;
         2'b10:   w_wval = w_old | csr_wdata;
         2'b11:   w_wval = w_old & ~csr_wdata;
         default: w_wval = w_old;
      endcase
   end

   // csrrs/csrrc with a zero operand are pure reads and never write
   assign w_do_write   = (csr_op != 2'b00) && !(csr_op[1] && (csr_wdata == 32'h0));
   assign csr_illegal  = (csr_op != 2'b00) && (!w_mapped || (w_do_write && w_ro));
   assign w_csr_we     = w_do_write && w_mapped && !w_ro;
   assign csr_rdata    = w_old;

   assign w_irq_entry  = irq_take & irq_valid;
   assign w_evt_block  = trap_req | w_irq_entry | mret;
   assign w_csr_commit = w_csr_we & ~w_evt_block;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mie          <= '0;
         r_mtvec        <= MTVEC_RESET & ~32'h2;
         r_mscratch     <= '0;
         r_mepc         <= '0;
         r_mcause       <= '0;
         r_mtval        <= '0;
         r_msip         <= 1'b0;
         r_mtip         <= 1'b0;
         r_trap_taken   <= 1'b0;
      end else begin
         r_msip       <= irq_sw;
         r_mtip       <= irq_timer;
         r_trap_taken <= 1'b0;
         if (trap_req) begin
            r_mepc         <= current_pc & ~32'h3;
            r_mcause       <= {27'b0, trap_cause};
            r_mtval        <= trap_tval;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
            r_trap_taken   <= 1'b1;
         end else if (w_irq_entry) begin
            r_mepc         <= current_pc & ~32'h3;
            r_mcause       <= {1'b1, 26'b0, w_irq_code};
            r_mtval        <= '0;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
            r_trap_taken   <= 1'b1;
         end else if (mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
         end else if (w_csr_we) begin
            case (csr_addr)
               12'h300: begin
                  r_mstatus_mie  <= w_wval[3];
                  r_mstatus_mpie <= w_wval[7];
               end
               12'h304: r_mie      <= w_wval & MIE_MASK;
               12'h305: r_mtvec    <= w_wval & ~32'h2;
               12'h340: r_mscratch <= w_wval;
               12'h341: r_mepc     <= w_wval & ~32'h3;
               12'h342: r_mcause   <= w_wval;
               12'h343: r_mtval    <= w_wval;
               default: ;
            endcase
         end
      end
   end

   generate
      if (HAS_COUNTERS) begin : g_cnt
         // A committed write to either half replaces that counter's increment
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_mcycle   <= '0;
               r_minstret <= '0;
            end else begin
               if (w_csr_commit && csr_addr == 12'hB00)      r_mcycle[31:0]  <= w_wval;
               else if (w_csr_commit && csr_addr == 12'hB80) r_mcycle[63:32] <= w_wval;
               else                                          r_mcycle <= r_mcycle + 64'd1;

               if (w_csr_commit && csr_addr == 12'hB02)      r_minstret[31:0]  <= w_wval;
               else if (w_csr_commit && csr_addr == 12'hB82) r_minstret[63:32] <= w_wval;
               else if (instr_retire)                        r_minstret <= r_minstret + 64'd1;
            end
         end
      end else begin : g_nocnt
         assign r_mcycle   = '0;
         assign r_minstret = '0;
      end
   endgenerate

   assign w_base     = {r_mtvec[31:2], 2'b00};
   assign trap_pc    = (r_mtvec[0] && r_mcause[31]) ? (w_base + {r_mcause[29:0], 2'b00}) : w_base;
   assign trap_taken = r_trap_taken;
   assign mepc_out   = r_mepc;

endmodule

// File: tb/tb_csr_mtrap_unit.sv
// Directed bench for csr_mtrap_unit: CSR access, interrupt/exception entry,
// event priority, trap vector and counters against hand-computed values.
module tb_csr_mtrap_unit;

   logic        clk;
   logic        reset_n;
   logic [11:0] csr_addr;
   logic [1:0]  csr_op;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        trap_req;
   logic [4:0]  trap_cause;
   logic [31:0] trap_tval;
   logic        irq_sw;
   logic        irq_timer;
   logic        irq_ext;
   logic [3:0]  irq_local;
   logic        irq_valid;
   logic        irq_take;
   logic        mret;
   logic        instr_retire;
   logic [31:0] current_pc;
   logic        trap_taken;
   logic [31:0] trap_pc;
   logic [31:0] mepc_out;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] rd;

   localparam logic [1:0] OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;

   csr_mtrap_unit #(
      .NUM_LOCAL_IRQ(4),
      .SYNC_STAGES  (2),
      .MTVEC_RESET  (32'h0000_0203),
      .HAS_COUNTERS (1'b1)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
      .trap_req(trap_req), .trap_cause(trap_cause), .trap_tval(trap_tval),
      .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext), .irq_local(irq_local),
      .irq_valid(irq_valid), .irq_take(irq_take), .mret(mret),
      .instr_retire(instr_retire), .current_pc(current_pc),
      .trap_taken(trap_taken), .trap_pc(trap_pc), .mepc_out(mepc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      @(negedge clk);
      csr_addr = a; csr_op = op; csr_wdata = d;
      @(posedge clk); #1;
      csr_op = 2'b00;
   endtask

   task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
      csr_addr = a; csr_op = 2'b00;
      #1;
      d = csr_rdata;
   endtask

   task automatic take_irq(input logic [31:0] pc);
      @(negedge clk);
      current_pc = pc; irq_take = 1'b1;
      @(posedge clk); #1;
      irq_take = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; csr_addr = '0; csr_op = '0; csr_wdata = '0;
      trap_req = 1'b0; trap_cause = '0; trap_tval = '0;
      irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0; irq_local = '0;
      irq_take = 1'b0; mret = 1'b0; instr_retire = 1'b0; current_pc = '0;
      repeat (3) @(posedge clk);
      #1;
      csr_rd(12'h300, rd); check("rst_mstatus", rd, 32'h0000_1800);
      csr_rd(12'h305, rd); check("rst_mtvec", rd, 32'h0000_0201);
      csr_rd(12'h342, rd); check("rst_mcause", rd, 32'h0);
      check("rst_trap_pc", trap_pc, 32'h0000_0200);
      check("rst_trap_taken", {31'b0, trap_taken}, 32'h0);
      check("rst_irq_valid", {31'b0, irq_valid}, 32'h0);
      @(negedge clk); reset_n = 1'b1;

      // mstatus set/clear, read-only misa
      csr_wr(12'h300, OP_RS, 32'h8);
      csr_rd(12'h300, rd); check("rs_mstatus", rd, 32'h0000_1808);
      csr_wr(12'h300, OP_RC, 32'h8);
      csr_rd(12'h300, rd); check("rc_mstatus", rd, 32'h0000_1800);
      @(negedge clk);
      csr_addr = 12'h301; csr_op = OP_RW; csr_wdata = 32'h7FF;
      #1; check("misa_wr_illegal", {31'b0, csr_illegal}, 32'h1);
      csr_op = OP_RS; csr_wdata = 32'h0;
      #1; check("misa_rs0_legal", {31'b0, csr_illegal}, 32'h0);
      csr_op = OP_RW; csr_wdata = 32'h7FF;
      @(posedge clk); #1; csr_op = 2'b00;
      csr_rd(12'h301, rd); check("misa_unchanged", rd, 32'h4000_0100);
      csr_rd(12'hF14, rd); check("mhartid", rd, 32'h0);
      csr_wr(12'h341, OP_RW, 32'h0000_1237);
      csr_rd(12'h341, rd); check("mepc_lsb", rd, 32'h0000_1234);

      // external interrupt through the 2-stage synchronizer
      csr_wr(12'h304, OP_RW, 32'h0000_0800);
      csr_wr(12'h300, OP_RS, 32'h8);
      @(negedge clk); irq_ext = 1'b1;
      @(posedge clk); #1; check("ext_lat1", {31'b0, irq_valid}, 32'h0);
      @(posedge clk); #1; check("ext_lat2", {31'b0, irq_valid}, 32'h1);
      take_irq(32'h0000_0100);
      irq_ext = 1'b0;
      check("ext_trap_taken", {31'b0, trap_taken}, 32'h1);
      check("ext_mepc_out", mepc_out, 32'h0000_0100);
      csr_rd(12'h342, rd); check("ext_mcause", rd, 32'h8000_000B);
      csr_rd(12'h300, rd); check("ext_mstatus", rd, 32'h0000_1880);
      check("ext_trap_pc", trap_pc, 32'h0000_022C);
      check("ext_irq_valid_off", {31'b0, irq_valid}, 32'h0);
      @(posedge clk); #1; check("trap_taken_pulse", {31'b0, trap_taken}, 32'h0);

      // mret then an unmapped CSR
      @(negedge clk); mret = 1'b1;
      @(posedge clk); #1; mret = 1'b0;
      csr_rd(12'h300, rd); check("mret_mstatus", rd, 32'h0000_1888);
      @(negedge clk);
      csr_addr = 12'h7C0; csr_op = OP_RS; csr_wdata = 32'h0;
      #1;
      check("unmapped_illegal", {31'b0, csr_illegal}, 32'h1);
      check("unmapped_rdata", csr_rdata, 32'h0);
      csr_op = 2'b00;

      // vectored timer interrupt, then an exception in direct target
      csr_wr(12'h305, OP_RW, 32'h0000_1001);
      csr_wr(12'h304, OP_RW, 32'h0000_0080);
      @(negedge clk); irq_timer = 1'b1;
      @(posedge clk); #1; check("tmr_valid", {31'b0, irq_valid}, 32'h1);
      take_irq(32'h0000_0200);
      irq_timer = 1'b0;
      csr_rd(12'h342, rd); check("tmr_mcause", rd, 32'h8000_0007);
      check("tmr_trap_pc", trap_pc, 32'h0000_101C);
      @(negedge clk);
      trap_req = 1'b1; trap_cause = 5'd2; trap_tval = 32'h0000_DEAD; current_pc = 32'h300;
      @(posedge clk); #1; trap_req = 1'b0;
      check("exc_trap_pc", trap_pc, 32'h0000_1000);
      check("exc_mepc", mepc_out, 32'h0000_0300);
      csr_rd(12'h343, rd); check("exc_mtval", rd, 32'h0000_DEAD);
      csr_rd(12'h300, rd); check("exc_mstatus", rd, 32'h0000_1800);

      // trap_req, irq_take, mret and a CSR write in one cycle
      csr_wr(12'h300, OP_RS, 32'h8);
      @(negedge clk); irq_timer = 1'b1;
      @(posedge clk); #1; check("pri_valid", {31'b0, irq_valid}, 32'h1);
      @(negedge clk);
      trap_req = 1'b1; trap_cause = 5'd2; trap_tval = 32'h55; current_pc = 32'h400;
      irq_take = 1'b1; mret = 1'b1;
      csr_addr = 12'h340; csr_op = OP_RW; csr_wdata = 32'h1234;
      @(posedge clk); #1;
      trap_req = 1'b0; irq_take = 1'b0; mret = 1'b0; csr_op = 2'b00; irq_timer = 1'b0;
      csr_rd(12'h342, rd); check("pri_mcause", rd, 32'h0000_0002);
      csr_rd(12'h300, rd); check("pri_mstatus", rd, 32'h0000_1880);
      csr_rd(12'h343, rd); check("pri_mtval", rd, 32'h0000_0055);
      csr_rd(12'h340, rd); check("pri_mscratch_dropped", rd, 32'h0);
      check("pri_mepc", mepc_out, 32'h0000_0400);

      // interrupt priority among sw, timer and local lines
      csr_wr(12'h304, OP_RW, 32'h0003_0088);
      csr_rd(12'h304, rd); check("mie_mask", rd, 32'h0003_0088);
      irq_sw = 1'b1; irq_timer = 1'b1; irq_local = 4'b0011;
      csr_wr(12'h300, OP_RS, 32'h8);
      repeat (3) @(posedge clk); #1;
      csr_rd(12'h344, rd); check("mip_all", rd, 32'h0003_0088);
      take_irq(32'h500);
      csr_rd(12'h342, rd); check("prio_sw", rd, 32'h8000_0003);
      irq_sw = 1'b0;
      csr_wr(12'h300, OP_RS, 32'h8);
      take_irq(32'h504);
      csr_rd(12'h342, rd); check("prio_timer", rd, 32'h8000_0007);
      irq_timer = 1'b0;
      csr_wr(12'h300, OP_RS, 32'h8);
      take_irq(32'h508);
      csr_rd(12'h342, rd); check("prio_local16", rd, 32'h8000_0010);
      check("local_trap_pc", trap_pc, 32'h0000_1040);
      take_irq(32'h999);
      check("take_ignored_mepc", mepc_out, 32'h0000_0508);
      check("take_ignored_taken", {31'b0, trap_taken}, 32'h0);
      irq_local = 4'b0000;

      // counters
      csr_wr(12'hB80, OP_RW, 32'h0);
      csr_wr(12'hB00, OP_RW, 32'hFFFF_FFFF);
      csr_rd(12'hB00, rd); check("mcycle_wr", rd, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      csr_rd(12'hB00, rd); check("mcycle_wrap", rd, 32'h0);
      csr_rd(12'hB80, rd); check("mcycleh_carry", rd, 32'h1);
      csr_wr(12'hB00, OP_RW, 32'h5);
      csr_rd(12'hB00, rd); check("mcycle_5", rd, 32'h5);
      @(posedge clk); #1;
      csr_rd(12'hB00, rd); check("mcycle_6", rd, 32'h6);
      csr_wr(12'hB02, OP_RW, 32'hFFFF_FFFE);
      @(negedge clk); instr_retire = 1'b1;
      repeat (3) @(posedge clk);
      #1; instr_retire = 1'b0;
      csr_rd(12'hB02, rd); check("minstret_lo", rd, 32'h1);
      csr_rd(12'hB82, rd); check("minstret_hi", rd, 32'h1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
